imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the processor's instruction-memory interface. The core only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words to instruction memory at consecutive word addresses starting at 0.
- Holds the processor in reset while loading and releases it once the image is complete and valid.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, instruction-memory capacity in words (must be ≤ 2^ADDR_W).
- HALT_WORD, 32'h7FFF_FFFF, sentinel instruction that ends simulation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready at the rising edge.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- core_rst  out  1  active-low reset to the processor.
- done  out  1  image loaded; core released.
- error  out  1  load failed.
- word_cnt  out  ADDR_W+1  number of words written so far.
- halt_seen  out  1  the image contains HALT_WORD.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=0, done=0, error=0, word_cnt=0, halt_seen=0; byte index and length cleared.
- Reset mid-load: the load is aborted exactly as above. Memory contents are not cleared.
- States: IDLE, LEN, DATA, WRITE, CSUM (only with the optional feature), DONE, ERR.
- IDLE: lasts one cycle after reset/reload, then LEN. in_ready=0.
- LEN: in_ready=1. Accepts 4 bytes, LSB first, into a 32-bit length N.
  - N==0: go to DONE with no writes.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA.
- DATA: in_ready=1. Accepts 4 bytes LSB first into a word register. On the 4th accepted byte, go to WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr=word_cnt[ADDR_W-1:0], mem_wdata=assembled word, in_ready=0.
  - At the end of the cycle: word_cnt increments; halt_seen is set if the word equals HALT_WORD (sticky).
  - Next state: DATA if word_cnt+1<N, else DONE (or CSUM when enabled).
- Outside WRITE: mem_we=0. mem_addr and mem_wdata hold their last values.
- Throughput: 5 cycles per word minimum (4 accept + 1 write). in_valid gaps stall without loss.
- core_rst=0 in every state except DONE. In DONE: core_rst=1, done=1, in_ready=0; extra bytes are not accepted.
- ERR: error=1, core_rst=0, in_ready=0.
- reload in DONE or ERR: next state IDLE; core_rst drops to 0 on the same edge; word_cnt, halt_seen, done and error are cleared. reload in any other state is ignored.
- Simultaneous rst==0 and reload: rst wins.
- word_cnt never wraps, because N≤DEPTH is enforced.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to CSUM and accept 4 more bytes (LSB first) as the expected checksum.
  - The checksum is the modulo-2^32 sum of all written words; N==0 gives an expected checksum of 0, and CSUM is still entered.
  - Match: go to DONE. Mismatch: go to ERR, with the memory already written and core_rst held at 0.
- Undefined: CSUM state is absent; the last WRITE goes directly to DONE.

Test Plan:
- Load N=3 with words 0x00000013, 0x00100093, 0x7FFFFFFF, bytes streamed back-to-back -> three mem_we pulses at addresses 0,1,2 with exactly those data values; halt_seen=1; done=1 and core_rst=1 on the cycle after the 3rd write; word_cnt=3.
- N=0 -> no mem_we pulses; done=1 and core_rst=1 five cycles after reset release (checksum feature off).
- N=257 with DEPTH=256 -> error=1, core_rst stays 0, no writes, in_ready=0.
- Random in_valid gaps on a 2-word image -> identical writes to the gapless run; in_ready=0 during each WRITE cycle.
- rst pulled low after 6 bytes, then a full 1-word reload -> single write at address 0; no residue from the aborted byte index.
- With IMEM_LOADER_CHECKSUM_EN: 2 words 0x1 and 0x2 with checksum 0x3 -> done=1. The same words with checksum 0x4 -> error=1, core_rst=0; then a reload pulse -> state IDLE, error=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// The loader drives the slave modport; the feeding agent and memory side use master.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed little-endian byte stream to word writes,
// holding the core in reset until done. Optional checksum trailer: IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | one settling cycle after reset/reload
// LEN     | collecting 4-byte word count N
// DATA    | collecting 4 bytes of the next word
// WRITE   | one-cycle memory write of the assembled word
// CSUM    | collecting 4-byte expected checksum (feature builds only)
// DONE    | image complete, core released
// ERR     | load rejected, core held in reset
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] HALT_WORD = 32'h7FFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    imem_loader_if.slave      bus,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_cnt,
    output logic              halt_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              halt_q, halt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        accept;
    logic        last_byte;
    logic [31:0] assembled;
    logic        reload_ok;
    logic [31:0] cnt_next;

    // Bytes shift in from the top, so after four accepts the word is little-endian ordered.
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_byte = accept && (byte_idx_q == 2'd3);
    assign assembled = {bus.in_data, shift_q};
    assign reload_ok = reload && (state_q == S_DONE || state_q == S_ERR);
    assign cnt_next  = 32'(word_cnt_q) + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            halt_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            halt_q     <= halt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_LEN;
            S_LEN: begin
                if (last_byte) begin
                    if (assembled == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else if (assembled > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: if (last_byte) state_d = S_WRITE;
            S_WRITE: begin
                if (cnt_next < len_q) begin
                    state_d = S_DATA;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (last_byte) state_d = (assembled == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE: if (reload_ok) state_d = S_IDLE;
            S_ERR:  if (reload_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        halt_d     = halt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = assembled[31:8];
        end
        if (state_q == S_LEN && last_byte) len_d = assembled;
        // Address and data are captured on entry to WRITE and then held for the memory.
        if (state_q == S_DATA && last_byte) begin
            addr_d  = word_cnt_q[ADDR_W-1:0];
            wdata_d = assembled;
        end
        if (state_q == S_WRITE) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
            if (wdata_q == HALT_WORD) halt_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q + wdata_q;
`endif
        end
        if (state_q == S_IDLE) begin
            byte_idx_d = '0;
            len_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end
        if (reload_ok) begin
            word_cnt_d = '0;
            halt_d     = 1'b0;
        end
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        core_rst     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            S_LEN, S_DATA: bus.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: bus.in_ready = 1'b1;
`endif
            S_WRITE: bus.mem_we = 1'b1;
            S_DONE: begin
                core_rst = 1'b1;
                done     = 1'b1;
            end
            S_ERR: error = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign word_cnt      = word_cnt_q;
    assign halt_seen     = halt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand corner sequences and a
// randomized load loop checked against a word-list model of the image.
module tb_imem_loader;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] HALT   = 32'h7FFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             reload = 1'b0;
    logic             core_rst, done, error, halt_seen;
    logic [ADDR_W:0]  word_cnt;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk       (clk),
        .rst       (rst),
        .reload    (reload),
        .bus       (bus_if.slave),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error),
        .word_cnt  (word_cnt),
        .halt_seen (halt_seen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-side observer: record every write and insist the stream is stalled during it.
    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus_if.mem_addr);
            wr_data_q.push_back(bus_if.mem_wdata);
            chk("in_ready_in_write", {63'd0, bus_if.in_ready}, 64'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state_ready", {63'd0, bus_if.in_ready}, 64'd0);
        chk("rst_state_we", {63'd0, bus_if.mem_we}, 64'd0);
        chk("rst_state_addr", 64'(bus_if.mem_addr), 64'd0);
        chk("rst_state_wdata", 64'(bus_if.mem_wdata), 64'd0);
        chk("rst_state_flags", {60'd0, core_rst, done, error, halt_seen}, 64'd0);
        chk("rst_state_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b1;
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_flags", {60'd0, core_rst, done, error, halt_seen}, 64'd0);
        chk("reload_cnt", 64'(word_cnt), 64'd0);
    endtask

    // Called and returns on a negedge; each byte is accepted at the posedge after in_ready is seen.
    task automatic send_stream(input logic [7:0] bytes[$], input bit gaps);
        int guard;
        foreach (bytes[i]) begin
            if (gaps) begin
                bus_if.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = bytes[i];
            guard = 0;
            while (bus_if.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                chk("stream_stall_timeout", 64'(guard), 64'd0);
                break;
            end
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input int unsigned n, input logic [31:0] words[$],
                            input bit gaps, input bit csum_bad, input bit exp_done,
                            input bit exp_halt, input int unsigned exp_cnt);
        logic [7:0]  bytes[$];
        logic [31:0] sum;
        int          guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        sum = 32'd0;
        for (int b = 0; b < 4; b++) bytes.push_back(8'(n >> (8 * b)));
        foreach (words[i]) begin
            sum = sum + words[i];
            for (int b = 0; b < 4; b++) bytes.push_back(8'(words[i] >> (8 * b)));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n <= DEPTH) begin
            if (csum_bad) sum = sum + 32'd1;
            for (int b = 0; b < 4; b++) bytes.push_back(8'(sum >> (8 * b)));
        end
`endif
        send_stream(bytes, gaps);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (n > 0 && n <= DEPTH) begin
            chk({tag, "_last_write_we"}, {63'd0, bus_if.mem_we}, 64'd1);
            chk({tag, "_done_before_write"}, {63'd0, done}, 64'd0);
            @(negedge clk);
            chk({tag, "_done_after_write"}, {63'd0, done}, 64'd1);
        end
`endif
        guard = 0;
        while (done !== 1'b1 && error !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_term_timeout"}, {63'd0, guard >= 100}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
        chk({tag, "_error"}, {63'd0, error}, {63'd0, !exp_done});
        chk({tag, "_core_rst"}, {63'd0, core_rst}, {63'd0, exp_done});
        chk({tag, "_in_ready"}, {63'd0, bus_if.in_ready}, 64'd0);
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(exp_cnt));
        chk({tag, "_halt"}, {63'd0, halt_seen}, {63'd0, exp_halt});
        chk({tag, "_n_writes"}, 64'(wr_addr_q.size()), 64'(exp_cnt));
        for (int i = 0; i < wr_addr_q.size() && i < words.size(); i++) begin
            chk({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(i));
            chk({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(words[i]));
        end
    endtask

    typedef struct {
        string             tag;
        int unsigned       n;
        int unsigned       nw;
        logic [3:0][31:0]  w;
        bit                gaps;
        bit                csum_bad;
        bit                exp_done;
        bit                exp_halt;
        int unsigned       exp_cnt;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] words[$];
        logic [7:0]  part[$];
        int          cyc;
        bit          bad;
        bit          hl;
        int unsigned n;

        vecs[0] = '{"n3_halt", 3, 3, {32'd0, 32'h7FFF_FFFF, 32'h0010_0093, 32'h0000_0013},
                    1'b0, 1'b0, 1'b1, 1'b1, 3};
        vecs[1] = '{"n0", 0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{"n257", 257, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{"n2_gaps", 2, 2, {32'd0, 32'd0, 32'hCAFE_F00D, 32'h1234_5678},
                    1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[4] = '{"n4_full", 4, 4, {32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'h0000_0001},
                    1'b1, 1'b0, 1'b1, 1'b0, 4};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[5] = '{"csum_bad", 2, 2, {32'd0, 32'd0, 32'h2, 32'h1}, 1'b0, 1'b1, 1'b0, 1'b0, 2};
`else
        vecs[5] = '{"n2_small", 2, 2, {32'd0, 32'd0, 32'h2, 32'h1}, 1'b0, 1'b1, 1'b1, 1'b0, 2};
`endif

        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'd0;

        // Zero-length image streamed straight out of reset: fixed latency to done.
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'd0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("n0_latency", 64'(cyc), 64'd9);
`else
        chk("n0_latency", 64'(cyc), 64'd5);
`endif
        repeat (3) @(negedge clk);
        chk("done_ignores_bytes_ready", {63'd0, bus_if.in_ready}, 64'd0);
        chk("done_ignores_bytes_cnt", 64'(word_cnt), 64'd0);
        chk("done_holds", {62'd0, done, core_rst}, 64'd3);
        bus_if.in_valid = 1'b0;

        foreach (vecs[v]) begin
            do_reload();
            words.delete();
            for (int i = 0; i < int'(vecs[v].nw); i++) words.push_back(vecs[v].w[i]);
            run_load(vecs[v].tag, vecs[v].n, words, vecs[v].gaps, vecs[v].csum_bad,
                     vecs[v].exp_done, vecs[v].exp_halt, vecs[v].exp_cnt);
        end

        // Abort mid-word with reset, then a clean one-word image must land at address 0.
        do_reset();
        wr_addr_q.delete();
        wr_data_q.delete();
        part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_stream(part, 1'b0);
        chk("abort_no_writes", 64'(wr_addr_q.size()), 64'd0);
        do_reset();
        words = '{32'hA5A5_1234};
        run_load("after_abort", 1, words, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Randomized images against the word-list model.
        for (int r = 0; r < 8; r++) begin
            do_reload();
            n = $urandom_range(1, 6);
            words.delete();
            hl = 1'b0;
            for (int i = 0; i < int'(n); i++) begin
                words.push_back(($urandom_range(0, 3) == 0) ? HALT : $urandom);
                if (words[i] == HALT) hl = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 2) == 0);
`else
            bad = 1'b0;
`endif
            run_load("rand", n, words, $urandom_range(0, 1) == 1, bad, !bad, hl, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
